// File: rtl/qimi_ng.sv
// QL mouse interface: assembles PS/2 packets, accumulates scaled saturating motion and
// pays it out one step per acknowledge access, with a paced interrupt.
module qimi_ng #(
   parameter int ACC_W   = 10,
   parameter int SHIFT   = 0,
   parameter int HOLDOFF = 1000,
   parameter int WHEEL   = 0,
   parameter int TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       cpu_sel,
   input  logic [1:0] cpu_addr,
   output logic [7:0] cpu_data,
   output logic       irq
);
   // state | meaning
   // B0    | waiting for header byte (bit3 = 1)
   // B1    | waiting for X byte
   // B2    | waiting for Y byte
   // B3    | waiting for wheel byte (WHEEL = 1 only)
   typedef enum logic [1:0] {B0, B1, B2, B3} state_t;

   localparam int HO_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
   localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam int SW   = ACC_W + 2;
   localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(ACC_W-1){1'b0}}};
   localparam logic signed [SW-1:0] ONE     = {{(SW-1){1'b0}}, 1'b1};

   state_t state, state_nxt;
   logic take_hdr, take_x, take_y, pkt_done, pkt_done_q;
   logic [2:0] buttons;
   logic sgn_x, sgn_y, ovf_x, ovf_y;
   logic [7:0] xbyte, ybyte, y_src;
   logic [TO_W-1:0] to_cnt;
   logic to_hit;
   logic [HO_W-1:0] holdoff;
   logic ack_sel, ack_q, ack;
   logic signed [ACC_W-1:0] acc_x, acc_y, acc_w, dx, dy, dw;
   logic signed [8:0] x9, y9, x_sh, y_sh;
   logic signed [3:0] w4;
   logic x_mov, y_mov, w_mov, x_dir, y_dir, w_dir, any_mov;

   // Delta and ack step combined in one widened sum, then clamped.
   function automatic logic signed [ACC_W-1:0] acc_upd(input logic signed [ACC_W-1:0] acc,
                                                       input logic signed [ACC_W-1:0] delta,
                                                       input logic step_en);
      logic signed [SW-1:0] sum;
      sum = SW'(acc) + SW'(delta);
      if (step_en && (acc != '0))
         sum = acc[ACC_W-1] ? (sum + ONE) : (sum - ONE);
      if (sum > SAT_MAX)
         return SAT_MAX[ACC_W-1:0];
      else if (sum < SAT_MIN)
         return SAT_MIN[ACC_W-1:0];
      else
         return sum[ACC_W-1:0];
   endfunction

   assign to_hit  = (to_cnt == TO_W'(TIMEOUT));
   assign ack_sel = cpu_sel && (cpu_addr == 2'b11);
   assign ack     = ack_sel && !ack_q;

   always_comb begin
      state_nxt = state;
      take_hdr  = 1'b0;
      take_x    = 1'b0;
      take_y    = 1'b0;
      pkt_done  = 1'b0;
      case (state)
         B0: if (rx_valid && rx_data[3]) begin
               take_hdr  = 1'b1;
               state_nxt = B1;
            end
         B1: if (rx_valid) begin
               take_x    = 1'b1;
               state_nxt = B2;
            end else if (to_hit) state_nxt = B0;
         B2: if (rx_valid) begin
               take_y = 1'b1;
               if (WHEEL != 0) state_nxt = B3;
               else begin
                  pkt_done  = 1'b1;
                  state_nxt = B0;
               end
            end else if (to_hit) state_nxt = B0;
         B3: if (rx_valid) begin
               pkt_done  = 1'b1;
               state_nxt = B0;
            end else if (to_hit) state_nxt = B0;
         default: state_nxt = B0;
      endcase
   end

   // Without a wheel byte the packet completes on the Y byte itself.
   always_comb begin
      y_src = (WHEEL != 0) ? ybyte : rx_data;
      x9    = {sgn_x, xbyte};
      y9    = {sgn_y, y_src};
      x_sh  = x9 >>> SHIFT;
      y_sh  = y9 >>> SHIFT;
      w4    = rx_data[3:0];
      dx    = '0;
      dy    = '0;
      dw    = '0;
      if (pkt_done) begin
         if (!ovf_x) dx = ACC_W'(x_sh);
         if (!ovf_y) dy = ACC_W'(y_sh);
         if (WHEEL != 0) dw = ACC_W'(w4);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= B0;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         buttons    <= '0;
         sgn_x      <= 1'b0;
         sgn_y      <= 1'b0;
         ovf_x      <= 1'b0;
         ovf_y      <= 1'b0;
         xbyte      <= '0;
         ybyte      <= '0;
         to_cnt     <= '0;
         acc_x      <= '0;
         acc_y      <= '0;
         acc_w      <= '0;
         ack_q      <= 1'b0;
         pkt_done_q <= 1'b0;
         holdoff    <= '0;
         irq        <= 1'b0;
      end else begin
         if (take_hdr) begin
            buttons <= rx_data[2:0];
            sgn_x   <= rx_data[4];
            sgn_y   <= rx_data[5];
            ovf_x   <= rx_data[6];
            ovf_y   <= rx_data[7];
         end
         if (take_x) xbyte <= rx_data;
         if (take_y) ybyte <= rx_data;
         if ((state == B0) || rx_valid || to_hit) to_cnt <= '0;
         else                                     to_cnt <= to_cnt + 1'b1;
         acc_x      <= acc_upd(acc_x, dx, ack);
         acc_y      <= acc_upd(acc_y, dy, ack);
         acc_w      <= acc_upd(acc_w, dw, ack);
         ack_q      <= ack_sel;
         pkt_done_q <= pkt_done;
         // Ack reload takes priority over the packet-complete arm.
         if (ack) begin
            holdoff <= HO_W'(HOLDOFF);
            irq     <= 1'b0;
         end else if (pkt_done_q && (holdoff == '0)) begin
            holdoff <= HO_W'(1);
         end else if (holdoff != '0) begin
            holdoff <= holdoff - 1'b1;
            if ((holdoff == HO_W'(1)) && any_mov) irq <= 1'b1;
         end
      end
   end

   always_comb begin
      x_mov   = (acc_x != '0);
      y_mov   = (acc_y != '0);
      w_mov   = (acc_w != '0);
      x_dir   = !acc_x[ACC_W-1];
      y_dir   = !acc_y[ACC_W-1];
      w_dir   = !acc_w[ACC_W-1];
      any_mov = x_mov || y_mov || w_mov;
      cpu_data = 8'h00;
      if (cpu_sel) begin
         case (cpu_addr)
            2'b00:   cpu_data = {2'b00, !buttons[0], !buttons[1], !buttons[2], 3'b000};
            2'b01:   cpu_data = {6'b0, w_mov, w_dir};
            2'b10:   cpu_data = {2'b00, y_mov, x_dir, 1'b0, x_mov, 1'b0, y_dir};
            default: cpu_data = 8'h00;
         endcase
      end
   end
endmodule

// File: tb/tb_qimi_ng.sv
// Bench for qimi_ng: a standard 3-byte instance and a wheel/shift instance, checked with
// vector tables, directed corner sequences and random packets against an integer model.
module tb_qimi_ng;
   localparam int AW = 10;
   localparam int HO = 16;
   localparam int TO = 40;

   logic clk = 1'b0;
   logic reset;
   logic [7:0] rx_data[2];
   logic       rx_valid[2];
   logic       cpu_sel[2];
   logic [1:0] cpu_addr[2];
   logic [7:0] cpu_data[2];
   logic       irq[2];

   always #5 clk = ~clk;

   qimi_ng #(.ACC_W(AW), .SHIFT(0), .HOLDOFF(HO), .WHEEL(0), .TIMEOUT(TO)) u_std (
      .clk(clk), .reset(reset), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
      .cpu_sel(cpu_sel[0]), .cpu_addr(cpu_addr[0]), .cpu_data(cpu_data[0]), .irq(irq[0]));

   qimi_ng #(.ACC_W(AW), .SHIFT(2), .HOLDOFF(HO), .WHEEL(1), .TIMEOUT(TO)) u_whl (
      .clk(clk), .reset(reset), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
      .cpu_sel(cpu_sel[1]), .cpu_addr(cpu_addr[1]), .cpu_data(cpu_data[1]), .irq(irq[1]));

   typedef struct {
      logic [7:0] b0, b1, b2;
      logic [7:0] e00, e10;
   } vec_t;

   int n_err = 0;
   int n_chk = 0;
   int m_x[2], m_y[2], m_w[2], m_btn[2];

   function automatic int sat(input int v);
      if (v > (1 << (AW - 1)) - 1) return (1 << (AW - 1)) - 1;
      if (v < -(1 << (AW - 1)))    return -(1 << (AW - 1));
      return v;
   endfunction

   // Floor division by 2^s, i.e. what an arithmetic right shift means numerically.
   function automatic int shr(input int v, input int s);
      int d;
      d = 1 << s;
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   function automatic int sgn(input int v);
      return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
   endfunction

   function automatic int sh_of(input int u);
      return (u == 0) ? 0 : 2;
   endfunction

   function automatic logic [7:0] exp_reg(input int u, input int a);
      logic [2:0] b;
      b = 3'(m_btn[u]);
      case (a)
         0:       return {2'b00, ~b[0], ~b[1], ~b[2], 3'b000};
         1:       return {6'b0, m_w[u] != 0, m_w[u] >= 0};
         2:       return {2'b00, m_y[u] != 0, m_x[u] >= 0, 1'b0, m_x[u] != 0, 1'b0, m_y[u] >= 0};
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_x[u] = 0; m_y[u] = 0; m_w[u] = 0; m_btn[u] = 0;
      end
   endtask

   task automatic model_update(input int u, input bit pkt, input int b0, input int b1,
                               input int b2, input int b3, input bit ack);
      int dx, dy, dw, sx, sy, sw;
      dx = 0; dy = 0; dw = 0;
      sx = ack ? sgn(m_x[u]) : 0;
      sy = ack ? sgn(m_y[u]) : 0;
      sw = ack ? sgn(m_w[u]) : 0;
      if (pkt) begin
         if ((b0 & 'h40) == 0) dx = shr(((b0 & 'h10) != 0) ? b1 - 256 : b1, sh_of(u));
         if ((b0 & 'h80) == 0) dy = shr(((b0 & 'h20) != 0) ? b2 - 256 : b2, sh_of(u));
         if (u != 0) dw = ((b3 & 15) >= 8) ? (b3 & 15) - 16 : (b3 & 15);
         m_btn[u] = b0 & 7;
      end
      m_x[u] = sat(m_x[u] + dx - sx);
      m_y[u] = sat(m_y[u] + dy - sy);
      m_w[u] = sat(m_w[u] + dw - sw);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic send_byte(input int u, input logic [7:0] b);
      rx_data[u]  = b;
      rx_valid[u] = 1'b1;
      tick();
      rx_valid[u] = 1'b0;
   endtask

   task automatic send_pkt(input int u, input int b0, input int b1, input int b2,
                           input int b3, input int gap);
      send_byte(u, 8'(b0)); repeat (gap) tick();
      send_byte(u, 8'(b1)); repeat (gap) tick();
      send_byte(u, 8'(b2));
      if (u != 0) begin
         repeat (gap) tick();
         send_byte(u, 8'(b3));
      end
      model_update(u, 1'b1, b0, b1, b2, b3, 1'b0);
   endtask

   task automatic do_ack(input int u);
      cpu_sel[u]  = 1'b1;
      cpu_addr[u] = 2'b11;
      tick();
      cpu_sel[u]  = 1'b0;
      cpu_addr[u] = 2'b00;
      tick();
      model_update(u, 1'b0, 0, 0, 0, 0, 1'b1);
   endtask

   task automatic rd(input int u, input int a, output logic [7:0] d);
      cpu_sel[u]  = 1'b1;
      cpu_addr[u] = 2'(a);
      #1;
      d = cpu_data[u];
      cpu_sel[u]  = 1'b0;
      cpu_addr[u] = 2'b00;
   endtask

   task automatic check_regs(input int u, input string name);
      logic [7:0] d;
      for (int a = 0; a < 4; a++) begin
         rd(u, a, d);
         check($sformatf("%s_u%0d_a%0d", name, u, a), d, exp_reg(u, a));
      end
   endtask

   task automatic check_rd(input int u, input int a, input string name, input int exp);
      logic [7:0] d;
      rd(u, a, d);
      check(name, d, exp);
   endtask

   // Counts acks until x stops moving; that count is |x_acc|.
   task automatic drain_x(input int u, output int n);
      logic [7:0] d;
      n = 0;
      rd(u, 2, d);
      while (d[2] && n < 2000) begin
         do_ack(u);
         n++;
         rd(u, 2, d);
      end
      if (d[2]) begin
         n_chk++;
         n_err++;
         $display("FAIL drain_bound: x_mov still set after %0d acks", n);
      end
   endtask

   task automatic hold_ack(input int u, input int cycles);
      cpu_sel[u]  = 1'b1;
      cpu_addr[u] = 2'b11;
      repeat (cycles) tick();
      cpu_sel[u]  = 1'b0;
      cpu_addr[u] = 2'b00;
      tick();
      model_update(u, 1'b0, 0, 0, 0, 0, 1'b1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int n;
      vt[0] = '{8'h08, 8'h03, 8'h00, 8'h38, 8'h15};
      vt[1] = '{8'h18, 8'hFF, 8'h00, 8'h38, 8'h05};
      vt[2] = '{8'h09, 8'h00, 8'h05, 8'h18, 8'h31};
      vt[3] = '{8'h2A, 8'h00, 8'h80, 8'h28, 8'h30};
      vt[4] = '{8'h4F, 8'h10, 8'h01, 8'h00, 8'h31};
      vt[5] = '{8'h8C, 8'h02, 8'h02, 8'h30, 8'h15};

      for (int u = 0; u < 2; u++) begin
         rx_data[u] = 8'h00; rx_valid[u] = 1'b0; cpu_sel[u] = 1'b0; cpu_addr[u] = 2'b00;
      end
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      model_reset();

      // Reset values, both instances.
      for (int u = 0; u < 2; u++) begin
         check_rd(u, 0, "rst_a00", 8'h38);
         check_rd(u, 1, "rst_a01", 8'h01);
         check_rd(u, 2, "rst_a10", 8'h11);
         check_rd(u, 3, "rst_a11", 8'h00);
         check("rst_irq", irq[u], 0);
      end
      cpu_sel[0] = 1'b0; cpu_addr[0] = 2'b10; #1;
      check("unselected", cpu_data[0], 8'h00);
      cpu_addr[0] = 2'b00;

      // Vector table: one packet after reset.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         send_pkt(0, vt[i].b0, vt[i].b1, vt[i].b2, 0, 0);
         check_rd(0, 0, $sformatf("vec%0d_a00", i), vt[i].e00);
         check_rd(0, 2, $sformatf("vec%0d_a10", i), vt[i].e10);
      end

      // First irq timing and paced re-assertion over three acks.
      do_reset();
      send_pkt(0, 'h08, 'h03, 'h00, 0, 0);
      check("irq_edge_n", irq[0], 0);
      check_rd(0, 2, "pkt3_a10", 8'h15);
      tick();
      check("irq_edge_n1", irq[0], 0);
      tick();
      check("irq_edge_n2", irq[0], 1);
      for (int a = 0; a < 3; a++) begin
         do_ack(0);
         check($sformatf("irq_clr_ack%0d", a), irq[0], 0);
         repeat (HO) tick();
         check($sformatf("irq_after_ack%0d", a), irq[0], (a < 2) ? 1 : 0);
      end
      check_rd(0, 2, "drained_a10", 8'h11);

      // Garbage byte, then held select gives exactly one step.
      do_reset();
      send_byte(0, 8'h07);
      send_pkt(0, 'h18, 'hFF, 'h00, 0, 0);
      check_rd(0, 2, "garb_a10", 8'h05);
      hold_ack(0, 10);
      check_rd(0, 2, "hold_a10", 8'h11);
      do_reset();
      send_pkt(0, 'h18, 'hFD, 'h00, 0, 0);
      hold_ack(0, 10);
      check_rd(0, 2, "hold3_a10", 8'h05);
      drain_x(0, n);
      check("hold3_rem", n, 2);

      // Ack coinciding with packet complete.
      do_reset();
      send_pkt(0, 'h08, 'h02, 'h00, 0, 0);
      repeat (3) tick();
      send_byte(0, 8'h08);
      send_byte(0, 8'h05);
      rx_data[0] = 8'h00; rx_valid[0] = 1'b1; cpu_sel[0] = 1'b1; cpu_addr[0] = 2'b11;
      tick();
      rx_valid[0] = 1'b0; cpu_sel[0] = 1'b0; cpu_addr[0] = 2'b00;
      model_update(0, 1'b1, 'h08, 'h05, 'h00, 0, 1'b1);
      check("coinc_irq_m", irq[0], 0);
      tick();
      repeat (HO - 2) tick();
      check("coinc_irq_early", irq[0], 0);
      tick();
      check("coinc_irq_holdoff", irq[0], 1);
      drain_x(0, n);
      check("coinc_acc", n, 6);

      // Reset while irq high and mid-packet.
      do_reset();
      send_pkt(0, 'h08, 'h01, 'h00, 0, 0);
      repeat (3) tick();
      check("rst_pre_irq", irq[0], 1);
      send_byte(0, 8'h08);
      send_byte(0, 8'h05);
      reset = 1'b1;
      tick();
      check("rst_irq_drop", irq[0], 0);
      tick();
      reset = 1'b0;
      model_reset();
      send_pkt(0, 'h08, 'h01, 'h00, 0, 0);
      check_rd(0, 2, "rst_mid_a10", 8'h15);
      drain_x(0, n);
      check("rst_mid_acc", n, 1);

      // Saturation both ways.
      do_reset();
      repeat (6) send_pkt(0, 'h08, 'hFF, 'h00, 0, 0);
      drain_x(0, n);
      check("sat_pos", n, 511);
      do_reset();
      repeat (6) send_pkt(0, 'h18, 'h01, 'h00, 0, 0);
      check_rd(0, 2, "sat_neg_a10", 8'h05);
      drain_x(0, n);
      check("sat_neg", n, 512);

      // Shift, wheel and resync on the wheel instance.
      do_reset();
      send_pkt(1, 'h08, 'h07, 'h00, 'h00, 0);
      drain_x(1, n);
      check("shift_pos7", n, 1);
      send_pkt(1, 'h18, 'hF9, 'h00, 'h00, 0);
      check_rd(1, 2, "shift_neg_a10", 8'h05);
      drain_x(1, n);
      check("shift_neg7", n, 2);
      send_pkt(1, 'h08, 'h00, 'h00, 'h0F, 0);
      check_rd(1, 1, "wheel_m1_a01", 8'h02);
      send_byte(1, 8'h08);
      repeat (TO + 5) tick();
      send_pkt(1, 'h08, 'h04, 'h00, 'h01, 0);
      check_rd(1, 1, "resync_a01", 8'h01);
      drain_x(1, n);
      check("resync_x", n, 1);
      send_byte(1, 8'h08);
      repeat (TO - 5) tick();
      send_byte(1, 8'h08);
      send_byte(1, 8'h00);
      send_byte(1, 8'h0F);
      model_update(1, 1'b1, 'h08, 'h08, 'h00, 'h0F, 1'b0);
      check_rd(1, 1, "stall_a01", 8'h02);
      drain_x(1, n);
      check("stall_x", n, 2);

      // Random packets and acks against the model.
      for (int u = 0; u < 2; u++) begin
         do_reset();
         for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 9) < 6) begin
               if ($urandom_range(0, 3) == 0)
                  send_byte(u, 8'($urandom_range(0, 255)) & 8'hF7);
               send_pkt(u, int'($urandom_range(0, 255)) | 'h08, int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 3)));
            end else begin
               do_ack(u);
            end
            check_regs(u, "rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
